// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_MUL  = 4'd12,
    OP_DIV  = 4'd13,
    OP_SRA  = 4'd14,
    OP_RSVD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) engine.
// One bit per clock; start loads operands, done marks the final step, whose
// result is presented combinationally on res_lo/res_hi in that same cycle.
module alu_muldiv_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         done,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi
);
  import alu_pkg::*;

  localparam int CW = $clog2(W + 1);

  // hi_q: product high half / partial remainder
  // lo_q: multiplier being shifted out / dividend shifting into quotient
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;

  logic [W:0]    mul_sum;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_diff;
  logic [W-1:0]  step_hi, step_lo;

  // One iteration of the selected algorithm, computed from the current registers
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    rem_sh   = {hi_q, lo_q[W-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (div_q) begin
      // Negative trial difference (bit W set) means restore the shifted remainder
      if (!rem_diff[W]) begin
        step_hi = rem_diff[W-1:0];
        step_lo = {lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[W-1:0];
        step_lo = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Load on start, otherwise step while the counter is running
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (start) begin
      hi_d  = '0;
      lo_d  = op_a;
      b_d   = op_b;
      cnt_d = CW'(W);
      div_d = is_div;
    end else if (cnt_q != '0) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Engine registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign done   = (cnt_q == CW'(1));
  assign res_lo = step_lo;
  assign res_hi = step_hi;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/branch ops plus iterative
// unsigned mul/div.
// Handshake: a request is taken on a rising edge where in_valid and in_ready
// are both 1; in_ready is 1 only in IDLE. out_valid is a one-cycle pulse with
// no backpressure; result outputs hold until the next pulse.
module mc_alu #(
  parameter int bit_size = 32,
  parameter int sh_w     = $clog2(bit_size)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          ALUOp,
  input  logic [bit_size-1:0] scr1,
  input  logic [bit_size-1:0] scr2,
  input  logic [sh_w-1:0]     shamt,
  output logic [bit_size-1:0] ALU_result,
  output logic [bit_size-1:0] ALU_hi,
  output logic                Zero,
  output logic                out_valid
);
  import alu_pkg::*;

  alu_state_e          state_q, state_d;
  logic [bit_size-1:0] result_q, result_d;
  logic [bit_size-1:0] hi_q, hi_d;
  logic                zero_q, zero_d;
  logic                out_valid_q, out_valid_d;

  alu_op_e             op;
  logic [bit_size-1:0] alu_res;
  logic                alu_zero;

  logic                mds_start;
  logic                mds_is_div;
  logic                mds_done;
  logic [bit_size-1:0] mds_lo, mds_hi;

  assign op = alu_op_e'(ALUOp);

  // Single-cycle operation results
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (op)
      OP_ADD: alu_res = scr1 + scr2;
      OP_SUB: alu_res = scr1 - scr2;
      OP_AND: alu_res = scr1 & scr2;
      OP_OR:  alu_res = scr1 | scr2;
      OP_XOR: alu_res = scr1 ^ scr2;
      OP_NOR: alu_res = ~(scr1 | scr2);
      OP_SLT: alu_res = {{(bit_size-1){1'b0}}, ($signed(scr1) < $signed(scr2))};
      OP_SLL: alu_res = scr1 << shamt;
      OP_SRL: alu_res = scr1 >> shamt;
      OP_SRA: alu_res = $unsigned($signed(scr1) >>> shamt);
      OP_BEQ: alu_zero = (scr1 == scr2);
      OP_BNE: alu_zero = (scr1 != scr2);
      default: begin
        alu_res  = '0;
        alu_zero = 1'b0;
      end
    endcase
  end

  // Control FSM next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    mds_start   = 1'b0;
    mds_is_div  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mds_start = 1'b1;
            state_d   = S_BUSY;
          end else if (op == OP_DIV) begin
            if (scr2 == '0) begin
              // Divide by zero resolves immediately without iterating
              result_d    = '1;
              hi_d        = scr1;
              zero_d      = 1'b0;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              mds_start  = 1'b1;
              mds_is_div = 1'b1;
              state_d    = S_BUSY;
            end
          end else begin
            result_d    = alu_res;
            hi_d        = '0;
            zero_d      = alu_zero;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (mds_done) begin
          result_d    = mds_lo;
          hi_d        = mds_hi;
          zero_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any simultaneous request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_muldiv_seq #(
    .W(bit_size)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mds_start),
    .is_div (mds_is_div),
    .op_a   (scr1),
    .op_b   (scr2),
    .done   (mds_done),
    .res_lo (mds_lo),
    .res_hi (mds_hi)
  );

  assign in_ready   = (state_q == S_IDLE);
  assign ALU_result = result_q;
  assign ALU_hi     = hi_q;
  assign Zero       = zero_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed testbench for mc_alu: a 32-bit instance and a 16-bit instance
// share operand inputs; each has its own in_valid.
module tb_mc_alu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  alu_op;
  logic [31:0] scr1, scr2;
  logic [4:0]  shamt;

  logic        a_in_valid, a_in_ready, a_zero, a_out_valid;
  logic [31:0] a_res, a_hi;
  logic        b_in_valid, b_in_ready, b_zero, b_out_valid;
  logic [15:0] b_res, b_hi;

  mc_alu #(.bit_size(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ALUOp(alu_op), .scr1(scr1), .scr2(scr2), .shamt(shamt),
    .ALU_result(a_res), .ALU_hi(a_hi), .Zero(a_zero), .out_valid(a_out_valid)
  );

  mc_alu #(.bit_size(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ALUOp(alu_op), .scr1(scr1[15:0]), .scr2(scr2[15:0]), .shamt(shamt[3:0]),
    .ALU_result(b_res), .ALU_hi(b_hi), .Zero(b_zero), .out_valid(b_out_valid)
  );

  // Observation mux selecting the instance under test
  bit          sel_b;
  logic [31:0] m_res, m_hi;
  logic        m_z, m_ov, m_rdy;
  assign m_res = sel_b ? {16'h0, b_res} : a_res;
  assign m_hi  = sel_b ? {16'h0, b_hi}  : a_hi;
  assign m_z   = sel_b ? b_zero      : a_zero;
  assign m_ov  = sel_b ? b_out_valid : a_out_valid;
  assign m_rdy = sel_b ? b_in_ready  : a_in_ready;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  int          last_lat;
  bit          last_rdy_seen;
  logic        last_ov_after;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents one request, waits for its out_valid
  // (bounded), then one more cycle to confirm the pulse is single-cycle.
  task automatic run_op(input bit to_b, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] sh);
    sel_b  = to_b;
    alu_op = op;
    scr1   = x;
    scr2   = y;
    shamt  = sh;
    if (to_b) b_in_valid = 1'b1;
    else      a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    last_lat      = 0;
    last_rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      last_lat++;
      if (!m_ov && m_rdy) last_rdy_seen = 1'b1;
    end while (!m_ov && last_lat < 100);
    @(negedge clk);
    last_ov_after = m_ov;
  endtask

  task automatic check_op(input string tag, input int exp_lat, input logic [31:0] exp_res,
                          input logic [31:0] exp_hi, input logic exp_z);
    check_eq({tag, "_lat"},   last_lat, exp_lat);
    check_eq({tag, "_res"},   m_res, exp_res);
    check_eq({tag, "_hi"},    m_hi, exp_hi);
    check_eq({tag, "_zero"},  m_z, exp_z);
    check_eq({tag, "_pulse"}, last_ov_after, 1'b0);
  endtask

  // Four requests with in_valid held high; one result expected per cycle
  task automatic back_to_back(input bit to_b, input logic [3:0] ops[4],
                              input logic [31:0] xs[4], input logic [31:0] ys[4],
                              input logic [4:0] shs[4]);
    logic [31:0] exp_v;
    sel_b  = to_b;
    alu_op = ops[0]; scr1 = xs[0]; scr2 = ys[0]; shamt = shs[0];
    if (to_b) b_in_valid = 1'b1;
    else      a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        alu_op = ops[i+1]; scr1 = xs[i+1]; scr2 = ys[i+1]; shamt = shs[i+1];
      end else begin
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("b2b%0d_%0d_valid", to_b, i), m_ov, 1'b1);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check_eq($sformatf("b2b%0d_%0d_res", to_b, i), m_res, exp_v);
    end
    @(negedge clk);
    check_eq($sformatf("b2b%0d_idle", to_b), m_ov, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  t_ops[4];
  logic [31:0] t_xs[4], t_ys[4];
  logic [4:0]  t_sh[4];
  int          ov_count;

  initial begin
    rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    alu_op = 4'd0; scr1 = '0; scr2 = '0; shamt = '0; sel_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_res",   a_res, 32'h0);
    check_eq("rst_hi",    a_hi, 32'h0);
    check_eq("rst_zero",  a_zero, 1'b0);
    check_eq("rst_valid", a_out_valid, 1'b0);
    check_eq("rst_ready", a_in_ready, 1'b1);
    check_eq("rst_ready16", b_in_ready, 1'b1);
    rst = 1'b0;

    // Single-cycle ops, 32-bit
    run_op(0, 4'd1, 32'hFFFF_FFFF, 32'd1, 5'd0);   check_op("add_wrap", 1, 32'h0, 32'h0, 1'b0);
    run_op(0, 4'd2, 32'd5, 32'd7, 5'd0);           check_op("sub", 1, 32'hFFFF_FFFE, 32'h0, 1'b0);
    run_op(0, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);   check_op("slt_neg", 1, 32'd1, 32'h0, 1'b0);
    run_op(0, 4'd7, 32'd1, 32'hFFFF_FFFF, 5'd0);   check_op("slt_pos", 1, 32'd0, 32'h0, 1'b0);
    run_op(0, 4'd10, 32'd7, 32'd7, 5'd0);          check_op("beq_eq", 1, 32'h0, 32'h0, 1'b1);
    run_op(0, 4'd11, 32'd7, 32'd7, 5'd0);          check_op("bne_eq", 1, 32'h0, 32'h0, 1'b0);
    run_op(0, 4'd10, 32'd7, 32'd8, 5'd0);          check_op("beq_ne", 1, 32'h0, 32'h0, 1'b0);
    run_op(0, 4'd11, 32'd7, 32'd8, 5'd0);          check_op("bne_ne", 1, 32'h0, 32'h0, 1'b1);
    run_op(0, 4'd14, 32'h8000_0000, 32'd1, 5'd4);  check_op("sra", 1, 32'hF800_0000, 32'h0, 1'b0);
    run_op(0, 4'd9, 32'h8000_0000, 32'd1, 5'd4);   check_op("srl", 1, 32'h0800_0000, 32'h0, 1'b0);
    run_op(0, 4'd8, 32'd1, 32'd0, 5'd31);          check_op("sll", 1, 32'h8000_0000, 32'h0, 1'b0);
    run_op(0, 4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0); check_op("and", 1, 32'h00F0_1200, 32'h0, 1'b0);
    run_op(0, 4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0); check_op("or",  1, 32'hFFF0_FF34, 32'h0, 1'b0);
    run_op(0, 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0); check_op("xor", 1, 32'hFF00_ED34, 32'h0, 1'b0);
    run_op(0, 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0); check_op("nor", 1, 32'h000F_00CB, 32'h0, 1'b0);
    run_op(0, 4'd0, 32'd5, 32'd6, 5'd0);           check_op("nop", 1, 32'h0, 32'h0, 1'b0);
    run_op(0, 4'd15, 32'd5, 32'd6, 5'd0);          check_op("rsvd", 1, 32'h0, 32'h0, 1'b0);

    // Multi-cycle ops, 32-bit
    run_op(0, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check_op("mul_max", 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    check_eq("mul_ready_low", last_rdy_seen, 1'b0);
    run_op(0, 4'd1, 32'd2, 32'd3, 5'd0);           check_op("add_after_mul", 1, 32'd5, 32'h0, 1'b0);
    run_op(0, 4'd12, 32'd1234, 32'd5678, 5'd0);    check_op("mul_small", 33, 32'd7006652, 32'h0, 1'b0);
    run_op(0, 4'd13, 32'd100, 32'd7, 5'd0);
    check_op("div", 33, 32'd14, 32'd2, 1'b0);
    check_eq("div_ready_low", last_rdy_seen, 1'b0);
    run_op(0, 4'd13, 32'hFFFF_FFFF, 32'h0001_0000, 5'd0);
    check_op("div_big", 33, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    run_op(0, 4'd13, 32'd9, 32'd0, 5'd0);          check_op("div_zero", 1, 32'hFFFF_FFFF, 32'd9, 1'b0);

    // Reset aborts a multiply in progress
    sel_b = 1'b0;
    alu_op = 4'd12; scr1 = 32'd3; scr2 = 32'd4; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", a_in_ready, 1'b1);
    check_eq("abort_res",   a_res, 32'h0);
    check_eq("abort_hi",    a_hi, 32'h0);
    check_eq("abort_valid", a_out_valid, 1'b0);
    ov_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_out_valid) ov_count++;
    end
    check_eq("abort_no_valid", ov_count, 0);
    run_op(0, 4'd1, 32'd2, 32'd3, 5'd0);           check_op("add_after_abort", 1, 32'd5, 32'h0, 1'b0);

    // Reset wins over a simultaneous request
    rst = 1'b1; alu_op = 4'd1; scr1 = 32'd8; scr2 = 32'd8; a_in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_prio_valid", a_out_valid, 1'b0);
    check_eq("rst_prio_res",   a_res, 32'h0);

    // Back-to-back, 32-bit
    t_ops = '{4'd1, 4'd5, 4'd8, 4'd2};
    t_xs  = '{32'd1, 32'hFF, 32'd3, 32'd0};
    t_ys  = '{32'd2, 32'h0F, 32'd0, 32'd1};
    t_sh  = '{5'd0, 5'd0, 5'd4, 5'd0};
    exp_q.push_back(32'd3);
    exp_q.push_back(32'hF0);
    exp_q.push_back(32'h30);
    exp_q.push_back(32'hFFFF_FFFF);
    @(negedge clk);
    back_to_back(0, t_ops, t_xs, t_ys, t_sh);

    // 16-bit instance
    t_ops = '{4'd1, 4'd2, 4'd14, 4'd7};
    t_xs  = '{32'hFFFF, 32'd3, 32'h8000, 32'hFFFF};
    t_ys  = '{32'd2, 32'd5, 32'd0, 32'd1};
    t_sh  = '{5'd0, 5'd0, 5'd3, 5'd0};
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'hFFFE);
    exp_q.push_back(32'hF000);
    exp_q.push_back(32'h0001);
    back_to_back(1, t_ops, t_xs, t_ys, t_sh);
    run_op(1, 4'd12, 32'hFFFF, 32'hFFFF, 5'd0);
    check_op("mul16", 17, 32'h0001, 32'hFFFE, 1'b0);
    check_eq("mul16_ready_low", last_rdy_seen, 1'b0);
    run_op(1, 4'd13, 32'd100, 32'd7, 5'd0);        check_op("div16", 17, 32'd14, 32'd2, 1'b0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter bit_size, default 32: datapath width in bits, legal values 8..64.
REQ-002 Parameter sh_w, default $clog2(bit_size): shift-amount width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port in_valid  input  1  operation request qualifier.
REQ-006 Port in_ready  output  1  block can accept a request this cycle.
REQ-007 Port ALUOp  input  4  operation select, per encoding table in REQ-012.
REQ-008 Port scr1, scr2  input  bit_size  source operands.
REQ-009 Port shamt  input  sh_w  shift amount.
REQ-010 Port ALU_result  output  bit_size  result (low product / quotient for mul/div).
REQ-011 Port ALU_hi, Zero, out_valid  output  bit_size/1/1  high product or remainder; branch flag; result-valid pulse.

Function
REQ-012 ALUOp encoding: nop=0, add=1, sub=2, and=3, or=4, xor=5, nor=6, slt=7, sll=8, srl=9, beq=10, bne=11, mul=12, div=13, sra=14; 15 is reserved.
REQ-013 A request is accepted on a rising edge with in_valid=1 and in_ready=1; operands are sampled only at that edge.
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 Single-cycle ops (0-11, 14, 15) stay in IDLE; results are registered and out_valid=1 for exactly the cycle after acceptance; back-to-back acceptance is allowed every cycle.
REQ-016 add/sub are modulo 2^bit_size; slt is signed and gives 1 or 0; sll/srl are logical; sra is arithmetic; shifts use shamt, not scr2.
REQ-017 beq: Zero=1 iff scr1==scr2; bne: Zero=1 iff scr1!=scr2; every other op gives Zero=0 and ALU_result=0 for beq/bne/nop/15.
REQ-018 mul: unsigned iterative shift-add; IDLE->BUSY on acceptance; BUSY lasts bit_size cycles (counter counts down to 0); BUSY->DONE; DONE->IDLE after one cycle with out_valid=1; total latency bit_size+1 cycles.
REQ-019 mul result: {ALU_hi, ALU_result} = full 2*bit_size unsigned product.
REQ-020 div: unsigned restoring; same FSM timing as mul; ALU_result=quotient, ALU_hi=remainder.
REQ-021 div with scr2==0: skips BUSY (IDLE->DONE); ALU_result=all ones, ALU_hi=scr1; latency 1.
REQ-022 ALU_hi=0 for all ops except mul/div.
REQ-023 out_valid has no backpressure and is a single-cycle pulse; ALU_result, ALU_hi and Zero hold their last value until the next out_valid.
REQ-024 in_valid during BUSY/DONE is ignored; the requester must hold the request until in_ready=1.

Reset
REQ-025 rst=1 at a clock edge forces IDLE, counter=0, ALU_result=0, ALU_hi=0, Zero=0, out_valid=0; in_ready=1 in the following cycle.
REQ-026 rst during BUSY or DONE aborts the operation, produces no out_valid, and discards partial results.
REQ-027 rst has priority over a simultaneous request; that request is not accepted.

Structure
REQ-028 Shared package alu_pkg holds the ALUOp encodings (REQ-012) and the FSM state typedef.
REQ-029 Iterative mul/div datapath is one sub-module, alu_muldiv_seq (operand/accumulator registers, counter, done strobe); the single-cycle ops stay in mc_alu.

Verification
REQ-030 add 0xFFFFFFFF+1 -> ALU_result=0, Zero=0, out_valid 1 cycle later; sub 5-7 -> 0xFFFFFFFE; slt -1,1 -> 1.
REQ-031 beq 7,7 -> Zero=1; bne 7,7 -> Zero=0; sra 0x80000000,shamt=4 -> 0xF8000000; srl same -> 0x08000000.
REQ-032 mul 0xFFFFFFFF*0xFFFFFFFF -> ALU_hi=0xFFFFFFFE, ALU_result=0x00000001, out_valid exactly 33 cycles after acceptance, in_ready=0 throughout.
REQ-033 div 100/7 -> ALU_result=14, ALU_hi=2 at 33 cycles; div 9/0 -> ALU_result=0xFFFFFFFF, ALU_hi=9 at 1 cycle.
REQ-034 rst at BUSY cycle 10 of mul -> no out_valid, outputs 0, in_ready=1 next cycle; next add 2+3 -> 5.
REQ-035 Four back-to-back single-cycle ops, in_valid held high -> four consecutive out_valid pulses with in-order results; repeat with bit_size=16 (mul latency 17).
